// File: rtl/pool_pkg.sv
// Shared definitions for the pool_release / pool_apply pair: FSM state
// encoding and the default field widths used by both blocks.
package pool_pkg;

    localparam int DEF_WQE_INDEX_WIDTH   = 10;
    localparam int DEF_WQE_SOURCE_LENGTH = 11;
    localparam int DEF_FIFO_ADDR_WIDTH   = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } pool_state_t;

endpackage

// File: rtl/pool_release_if.sv
// Handshake bundle around pool_release: the incoming release request stream,
// the per-chunk pointer return stream and the completion notification stream.
// The slave modport is the pool_release view; master is its environment.
interface pool_release_if #(
    parameter int WQE_INDEX_WIDTH   = pool_pkg::DEF_WQE_INDEX_WIDTH,
    parameter int WQE_SOURCE_LENGTH = pool_pkg::DEF_WQE_SOURCE_LENGTH
) ();

    logic                                         s_axis_Prelease_valid;
    logic [WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH-1:0] s_axis_Prelease_id_len;
    logic                                         s_axis_Prelease_ready;

    logic                                         m_axis_Ptrrelease_valid;
    logic [WQE_INDEX_WIDTH-1:0]                   m_axis_Ptrrelease_id;
    logic [WQE_SOURCE_LENGTH-1:0]                 m_axis_Ptrrelease_idx;
    logic                                         m_axis_Ptrrelease_ready;

    logic                                         m_axis_Frelease_valid;
    logic [WQE_INDEX_WIDTH-1:0]                   m_axis_Frelease_id;
    logic [WQE_SOURCE_LENGTH-1:0]                 m_axis_Frelease_len;
    logic                                         m_axis_Frelease_ready;

    modport slave (
        input  s_axis_Prelease_valid, s_axis_Prelease_id_len,
        output s_axis_Prelease_ready,
        output m_axis_Ptrrelease_valid, m_axis_Ptrrelease_id, m_axis_Ptrrelease_idx,
        input  m_axis_Ptrrelease_ready,
        output m_axis_Frelease_valid, m_axis_Frelease_id, m_axis_Frelease_len,
        input  m_axis_Frelease_ready
    );

    modport master (
        output s_axis_Prelease_valid, s_axis_Prelease_id_len,
        input  s_axis_Prelease_ready,
        input  m_axis_Ptrrelease_valid, m_axis_Ptrrelease_id, m_axis_Ptrrelease_idx,
        output m_axis_Ptrrelease_ready,
        input  m_axis_Frelease_valid, m_axis_Frelease_id, m_axis_Frelease_len,
        output m_axis_Frelease_ready
    );

endinterface

// File: rtl/syn_fifo.sv
// Single-clock FIFO with a registered read port: dout updates on the edge
// that consumes rd_en. Pointers carry one extra wrap bit to tell full from
// empty. Writes while full and reads while empty are ignored.
module syn_fifo #(
    parameter int DATA_WIDTH = 21,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointer bookkeeping; reset flushes the contents by aligning the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written without reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
    end

    // Registered read data, valid the cycle after a read is requested.
    always_ff @(posedge clk) begin
        if (rst)        dout <= '0;
        else if (do_rd) dout <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

endmodule

// File: rtl/pool_release.sv
// pool_release: queues WQE release requests {len,id} and, one at a time in
// arrival order, returns each of the len chunks to the free pool (idx 0..len-1)
// followed by a single completion notification.
// Optional build macro POOL_RELEASE_STAT_EN adds saturating 32-bit counters of
// chunk handshakes and completion handshakes.
module pool_release
    import pool_pkg::*;
#(
    parameter int WQE_INDEX_WIDTH   = DEF_WQE_INDEX_WIDTH,
    parameter int WQE_SOURCE_LENGTH = DEF_WQE_SOURCE_LENGTH,
    parameter int FIFO_ADDR_WIDTH   = DEF_FIFO_ADDR_WIDTH
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    pool_release_if.slave bus
`ifdef POOL_RELEASE_STAT_EN
    ,
    output logic [31:0]   stat_chunks_released,
    output logic [31:0]   stat_reqs_done
`endif
);

    localparam int IW = WQE_INDEX_WIDTH;
    localparam int LW = WQE_SOURCE_LENGTH;
    localparam int DW = IW + LW;

    pool_state_t   state;
    pool_state_t   next_state;

    logic          fifo_wr;
    logic          fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic [IW-1:0] fifo_id;
    logic [LW-1:0] fifo_len;

    logic [IW-1:0] cur_id;
    logic [LW-1:0] cur_len;
    logic [LW-1:0] cur_idx;

    logic          ptr_valid;
    logic          fin_valid;
    logic          ptr_hs;
    logic          fin_hs;
    logic          last_beat;

    assign fifo_wr  = bus.s_axis_Prelease_valid && !fifo_full;
    assign fifo_id  = fifo_dout[IW-1:0];
    assign fifo_len = fifo_dout[DW-1:IW];

    assign ptr_hs    = ptr_valid && bus.m_axis_Ptrrelease_ready;
    assign fin_hs    = fin_valid && bus.m_axis_Frelease_ready;
    assign last_beat = (cur_idx == cur_len - LW'(1));

    assign bus.s_axis_Prelease_ready   = !fifo_full;
    assign bus.m_axis_Ptrrelease_valid = ptr_valid;
    assign bus.m_axis_Ptrrelease_id    = cur_id;
    assign bus.m_axis_Ptrrelease_idx   = cur_idx;
    assign bus.m_axis_Frelease_valid   = fin_valid;
    assign bus.m_axis_Frelease_id      = cur_id;
    assign bus.m_axis_Frelease_len     = cur_len;

    syn_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .wr_en (fifo_wr),
        .din   (bus.s_axis_Prelease_id_len),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next-state logic: pop, wait a cycle for the registered FIFO data, then
    // stream the chunks (skipped for an empty request) and notify completion.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (!fifo_empty) next_state = ST_POP;
            ST_POP:     next_state = ST_LOAD;
            ST_LOAD:    next_state = (fifo_len != '0) ? ST_RELEASE : ST_DONE;
            ST_RELEASE: if (ptr_hs && last_beat) next_state = ST_DONE;
            ST_DONE:    if (fin_hs) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from state, so the two valids are exclusive.
    always_comb begin
        fifo_rd   = (state == ST_POP);
        ptr_valid = (state == ST_RELEASE);
        fin_valid = (state == ST_DONE);
    end

    // Current-request registers: loaded from the FIFO, idx steps per chunk.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_id  <= '0;
            cur_len <= '0;
            cur_idx <= '0;
        end else if (state == ST_LOAD) begin
            cur_id  <= fifo_id;
            cur_len <= fifo_len;
            cur_idx <= '0;
        end else if (ptr_hs && !last_beat) begin
            cur_idx <= cur_idx + LW'(1);
        end
    end

`ifdef POOL_RELEASE_STAT_EN
    // Saturating statistics counters for chunks returned and requests finished.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_chunks_released <= '0;
            stat_reqs_done       <= '0;
        end else begin
            if (ptr_hs && stat_chunks_released != '1)
                stat_chunks_released <= stat_chunks_released + 32'd1;
            if (fin_hs && stat_reqs_done != '1)
                stat_reqs_done <= stat_reqs_done + 32'd1;
        end
    end
`endif

endmodule
